// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected neuron front end.
package fc_pkg;

    localparam int ACT_W    = 8;
    localparam int FC_IN    = 128;
    localparam int FC_OUT_W = 22;

    typedef logic [ACT_W-1:0] act_t;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        HOLD,
        RESULT
    } ld_state_t;

endpackage

// File: rtl/fc_act_loader_top.sv
// Loader plus neuron: streamed activations in, streamed ReLU result out.
module fc_act_loader_top
    import fc_pkg::*;
#(
    parameter int WIDTH  = ACT_W,
    parameter int IN     = FC_IN,
    parameter int OUT_W  = FC_OUT_W,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    input  logic [IN-1:0][WIDTH-1:0] w,
    input  logic [OUT_W-1:0]         bias,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     short_frame,
    output logic                     long_frame
);

    logic [IN-1:0][WIDTH-1:0] x;
    logic [OUT_W-1:0]         z;

    fc_act_loader #(
        .WIDTH  (WIDTH),
        .IN     (IN),
        .OUT_W  (OUT_W),
        .SETTLE (SETTLE)
    ) u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .x           (x),
        .z_in        (z),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .short_frame (short_frame),
        .long_frame  (long_frame)
    );

    fc_neuron #(
        .WIDTH (WIDTH),
        .IN    (IN),
        .OUT_W (OUT_W)
    ) u_neuron (
        .x    (x),
        .w    (w),
        .bias (bias),
        .z    (z)
    );

endmodule

// File: rtl/fc_neuron.sv
// Combinational fully-connected neuron: unsigned activations, signed weights,
// signed bias, ReLU output.
module fc_neuron #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT_W = 22
) (
    input  logic [IN-1:0][WIDTH-1:0] x,
    input  logic [IN-1:0][WIDTH-1:0] w,
    input  logic [OUT_W-1:0]         bias,
    output logic [OUT_W-1:0]         z
);

    // One guard bit so the pre-ReLU sum carries its sign.
    localparam int ACC_W = OUT_W + 1;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] xs;
    logic signed [ACC_W-1:0] ws;

    always_comb begin
        acc = ACC_W'($signed(bias));
        xs  = '0;
        ws  = '0;
        for (int i = 0; i < IN; i++) begin
            xs  = ACC_W'(x[i]);
            ws  = ACC_W'($signed(w[i]));
            acc = acc + xs * ws;
        end
        z = acc[ACC_W-1] ? '0 : acc[OUT_W-1:0];
    end

endmodule

// File: rtl/fc_act_loader.sv
// Streams activations into a parallel vector for a combinational neuron,
// waits for it to settle, then returns the result on a valid/ready stream.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int WIDTH  = ACT_W,
    parameter int IN     = FC_IN,
    parameter int OUT_W  = FC_OUT_W,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    output logic [IN-1:0][WIDTH-1:0] x,
    input  logic [OUT_W-1:0]         z_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     short_frame,
    output logic                     long_frame
);

    localparam int IW  = (IN > 1) ? $clog2(IN) : 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0]  LAST_IDX   = IW'(IN - 1);
    localparam logic [SCW-1:0] SETTLE_END = SCW'(SETTLE - 1);

    ld_state_t                 state_q, state_d;
    logic [IW-1:0]             wr_idx_q, wr_idx_d;
    logic [IN-1:0][WIDTH-1:0]  x_q, x_d;
    logic [SCW-1:0]            settle_cnt_q, settle_cnt_d;
    logic [OUT_W-1:0]          m_data_q, m_data_d;
    logic                      s_ready_q, s_ready_d;
    logic                      m_valid_q, m_valid_d;
    logic                      short_q, short_d;
    logic                      long_q, long_d;

    logic s_acc;
    logic m_acc;
    logic at_last;

    assign s_acc   = s_valid && s_ready_q;
    assign m_acc   = m_valid_q && m_ready;
    assign at_last = (wr_idx_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        x_d          = x_q;
        settle_cnt_d = settle_cnt_q;
        m_data_d     = m_data_q;
        short_d      = 1'b0;
        long_d       = 1'b0;

        case (state_q)
            FILL: begin
                if (s_acc) begin
                    x_d[wr_idx_q] = s_data;
                    if (at_last) begin
                        // wr_idx parks at IN-1 rather than wrapping.
                        long_d  = !s_last;
                        state_d = s_last ? HOLD : DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (s_last) begin
                            short_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
            end
            DRAIN: begin
                if (s_acc && s_last) state_d = HOLD;
            end
            HOLD: begin
                if (settle_cnt_q == SETTLE_END) begin
                    m_data_d     = z_in;
                    settle_cnt_d = '0;
                    state_d      = RESULT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (m_acc) begin
                    x_d          = '0;
                    wr_idx_d     = '0;
                    settle_cnt_d = '0;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // Ingress reopens one cycle after re-entering FILL, which keeps
        // s_ready and m_valid disjoint and both purely registered.
        s_ready_d = (state_d == DRAIN) || (state_d == FILL && state_q == FILL);
        m_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            x_q          <= '0;
            settle_cnt_q <= '0;
            m_data_q     <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            x_q          <= x_d;
            settle_cnt_q <= settle_cnt_d;
            m_data_q     <= m_data_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            short_q      <= short_d;
            long_q       <= long_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign x           = x_q;
    assign short_frame = short_q;
    assign long_frame  = long_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader with a behavioural neuron on x/z_in.
module tb_fc_act_loader;

    localparam int IN    = 128;
    localparam int WIDTH = 8;
    localparam int OUT_W = 22;

    // Weights w[i] = (i%9)-4, bias 100000.
    // Ramp frame 0..127: sum = 14*60 - 4*126 - 3*127 = -45  -> 99955.
    // Ten ones:          sum = (-4..4) + (-4)      = -4   -> 99996.
    localparam logic [31:0] EXP_RAMP  = 32'd99955;
    localparam logic [31:0] EXP_SHORT = 32'd99996;

    logic                     clk;
    logic                     rst_n;
    logic                     s_valid;
    logic                     s_ready;
    logic [WIDTH-1:0]         s_data;
    logic                     s_last;
    logic [IN-1:0][WIDTH-1:0] x;
    logic [OUT_W-1:0]         z_in;
    logic                     m_valid;
    logic                     m_ready;
    logic [OUT_W-1:0]         m_data;
    logic                     short_frame;
    logic                     long_frame;

    int checks;
    int failures;
    int bias;
    int nacc;

    fc_act_loader #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .SETTLE(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .x           (x),
        .z_in        (z_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .short_frame (short_frame),
        .long_frame  (long_frame)
    );

    always_comb begin
        nacc = bias;
        for (int i = 0; i < IN; i++) nacc = nacc + int'(x[i]) * ((i % 9) - 4);
        z_in = (nacc < 0) ? '0 : nacc[OUT_W-1:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic beat(input logic [WIDTH-1:0] d, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("s_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_mvalid();
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic ramp_frame();
        for (int i = 0; i < IN; i++) beat(8'(i), i == IN - 1);
    endtask

    initial begin
        logic ok;
        logic [OUT_W-1:0] held;
        checks   = 0;
        failures = 0;
        bias     = 100000;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b1;

        #12;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_pulses", 32'({short_frame, long_frame}), 32'd0);
        chk("rst_x5", 32'(x[5]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Full ramp frame; beat is cycle T, m_valid must be seen in T+3.
        ramp_frame();
        chk("hold_s_ready", 32'(s_ready), 32'd0);
        chk("hold_m_valid_t1", 32'(m_valid), 32'd0);
        chk("hold_x5", 32'(x[5]), 32'd5);
        chk("hold_x127", 32'(x[127]), 32'd127);
        @(negedge clk);
        chk("hold_m_valid_t2", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("m_valid_t3", 32'(m_valid), 32'd1);
        chk("full_m_data", 32'(m_data), EXP_RAMP);
        chk("excl_result", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("post_acc_m_valid", 32'(m_valid), 32'd0);
        chk("post_acc_s_ready", 32'(s_ready), 32'd0);
        chk("post_acc_x5_cleared", 32'(x[5]), 32'd0);
        @(negedge clk);
        chk("refill_s_ready", 32'(s_ready), 32'd1);

        // Short frame of ten ones under 20 cycles of backpressure.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) beat(8'd1, i == 9);
        chk("short_pulse", 32'(short_frame), 32'd1);
        chk("short_no_long", 32'(long_frame), 32'd0);
        chk("short_x9", 32'(x[9]), 32'd1);
        chk("short_x10_pad", 32'(x[10]), 32'd0);
        chk("short_x127_pad", 32'(x[127]), 32'd0);
        @(negedge clk);
        chk("short_pulse_end", 32'(short_frame), 32'd0);
        wait_mvalid();
        chk("short_m_data", 32'(m_data), EXP_SHORT);
        held = m_data;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!m_valid || m_data !== held || s_ready) ok = 1'b0;
        end
        chk("backpressure_stable", 32'(ok), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_m_valid", 32'(m_valid), 32'd0);
        chk("bp_release_x9_cleared", 32'(x[9]), 32'd0);
        chk("bp_release_s_ready_low", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("bp_release_s_ready", 32'(s_ready), 32'd1);

        // Long frame: 130 beats, extra two absorbed while s_ready stays high.
        for (int i = 0; i < 130; i++) begin
            beat(8'(i), i == 129);
            if (i == 127) begin
                chk("long_pulse", 32'(long_frame), 32'd1);
                chk("long_no_short", 32'(short_frame), 32'd0);
                chk("drain_s_ready", 32'(s_ready), 32'd1);
            end
            if (i == 128) chk("long_pulse_end", 32'(long_frame), 32'd0);
        end
        ok = 1'b1;
        for (int i = 0; i < IN; i++) if (x[i] !== 8'(i)) ok = 1'b0;
        chk("long_x_first128", 32'(ok), 32'd1);
        wait_mvalid();
        chk("long_m_data", 32'(m_data), EXP_RAMP);
        @(negedge clk);

        // Gapped ingress: one idle cycle between every beat.
        for (int i = 0; i < IN; i++) begin
            beat(8'(i), i == IN - 1);
            if (i == 63) chk("gap_x64_unwritten", 32'(x[64]), 32'd0);
            if (i != IN - 1) @(negedge clk);
        end
        chk("gap_x127", 32'(x[127]), 32'd127);
        wait_mvalid();
        chk("gap_m_data", 32'(m_data), EXP_RAMP);
        @(negedge clk);

        // Async reset in the middle of a fill.
        for (int i = 0; i < 60; i++) beat(8'(i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fill_s_ready", 32'(s_ready), 32'd0);
        chk("arst_fill_x5", 32'(x[5]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_fill_s_ready_back", 32'(s_ready), 32'd1);
        ramp_frame();
        wait_mvalid();
        chk("arst_fill_next_m_data", 32'(m_data), EXP_RAMP);
        @(negedge clk);

        // Async reset while a result is pending.
        m_ready = 1'b0;
        ramp_frame();
        wait_mvalid();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res_m_valid", 32'(m_valid), 32'd0);
        chk("arst_res_m_data", 32'(m_data), 32'd0);
        chk("arst_res_x127", 32'(x[127]), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) beat(8'd1, i == 9);
        wait_mvalid();
        chk("arst_res_next_m_data", 32'(m_data), EXP_SHORT);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_act_loader.md
Name: fc_act_loader

Overview:
Front-end sequencer for one combinational fully-connected neuron instance (128 inputs, 8-bit activations, 22-bit ReLU output).
- Accepts activations one per beat on a valid/ready stream and packs them into the parallel x vector.
- Holds that vector stable while the neuron settles, then registers the neuron result and offers it on a valid/ready output stream.
- Converts streaming ingress into the neuron's parallel input and its combinational result back into a handshaked stream.

Parameters:
WIDTH, 8, activation bit width (matches neuron WIDTH)
IN, 128, number of activations per frame / neuron inputs
OUT_W, 22, neuron result width (WIDTH*2 + adder-tree growth)
SETTLE, 2, cycles x is held stable before z is sampled (≥1; covers combinational tree delay)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  ingress activation valid
s_ready  out  1  ingress ready
s_data  in  WIDTH  activation value (unsigned pixel/activation)
s_last  in  1  marks final beat of a frame
x  out  WIDTH x [0:IN-1]  registered activation vector to neuron
z_in  in  OUT_W  combinational neuron result
m_valid  out  1  result valid
m_ready  in  1  result accepted
m_data  out  OUT_W  registered neuron result
short_frame  out  1  one-cycle pulse: frame ended before IN beats
long_frame  out  1  one-cycle pulse: frame exceeded IN beats

Behaviour:
- Reset (async, rst_n=0), all outputs forced:
  - state=FILL; wr_idx=0; every x entry=0; settle_cnt=0; m_data=0.
  - s_ready=0, m_valid=0, short_frame=0, long_frame=0.
  - s_ready rises the first cycle after rst_n deasserts.
- Reset mid-operation discards any partial frame and pending result.
- States: FILL, DRAIN, HOLD, RESULT.
- FILL: s_ready=1. A beat is accepted when s_valid&&s_ready.
  - Each accepted beat writes x[wr_idx]=s_data and increments wr_idx.
  - Accepted beat with wr_idx==IN-1 and s_last=1: go to HOLD.
  - Accepted beat with wr_idx==IN-1 and s_last=0: pulse long_frame, go to DRAIN.
  - Accepted beat with s_last=1 and wr_idx<IN-1: remaining entries keep their cleared value 0 (zero-pad); pulse short_frame; go to HOLD.
- DRAIN: s_ready=1. Accepted beats are discarded. The accepted beat with s_last=1 moves to HOLD.
- HOLD: s_ready=0.
  - x is frozen.
  - settle_cnt counts 0..SETTLE-1.
  - On the cycle settle_cnt==SETTLE-1: m_data<=z_in, go to RESULT.
- RESULT: m_valid=1; m_data stable until accepted.
  - On m_valid&&m_ready: all x entries cleared to 0, wr_idx=0, settle_cnt=0, go to FILL.
  - s_ready rises the following cycle.
- Latency:
  - Last ingress beat accepted at cycle T → m_valid at T+1+SETTLE (SETTLE=2 → T+3).
  - Minimum frame period: IN+SETTLE+2 cycles with m_ready held high.
- Width rules:
  - m_data is a pass-through of the neuron's ReLU output (non-negative, OUT_W bits).
  - No truncation, saturation or sign handling.
- Mutual exclusion: s_ready and m_valid are never both 1, so ingress and result handshakes cannot collide.
- short_frame and long_frame:
  - Registered and high exactly one cycle.
  - Never both high.
  - No effect on m_data beyond zero padding.
- wr_idx width: $clog2(IN); never wraps (the transition at IN-1 prevents it).

Decomposition:
- Shared package fc_pkg holds:
  - localparams ACT_W=8, FC_IN=128, FC_OUT_W=22.
  - typedef act_t (logic [ACT_W-1:0]).
  - typedef enum {FILL, DRAIN, HOLD, RESULT} ld_state_t.
- One natural sub-module: fc_act_loader_top, which instantiates fc_act_loader plus the neuron (layer) with x/z_in wired between them.
- The loader itself stays a single module.

Test Plan:
- Full frame: stream s_data=i%256 for i=0..127, s_last on beat 127, m_ready=1.
  - x[5]=5 and x[127]=127 during HOLD.
  - m_valid exactly 3 cycles after the last beat.
  - m_data equals the golden dot-product/ReLU value.
- Short frame: 10 beats, all value 1, s_last on beat 9.
  - short_frame pulses once.
  - x[10..127]=0.
  - m_data matches a golden model with zero padding.
- Long frame: 130 beats, s_last on beat 129.
  - long_frame pulses on beat 127.
  - Beats 128–129 are absorbed with s_ready=1.
  - x[0..127] equals the first 128 values.
- Backpressure: m_ready=0 for 20 cycles after m_valid.
  - m_valid and m_data stay stable.
  - s_ready stays 0.
  - After m_ready=1: buffer cleared, s_ready=1 next cycle.
- Gapped ingress: s_valid toggles 1/0 every cycle across a full frame.
  - Same m_data as the full-frame case.
  - wr_idx advances only on handshakes.
- Async reset: assert rst_n=0 mid-FILL at beat 60 and again during RESULT.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Next frame produces the correct result.
